// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: performs the data-memory access for the EX/MEM instruction
// over a req/ack handshake, stalls upstream while busy and drives the MEM/WB fields.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int DATA_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [1:0]        wb_ctlout,
  input  logic              branch,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [DATA_W-1:0] add_result,
  input  logic              zero,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rdata2out,
  input  logic [4:0]        five_bit_muxout,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              pcsrc,
  output logic [DATA_W-1:0] branch_target,
  output logic              wb_valid,
  output logic [1:0]        wb_ctl,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [4:0]        mem_wb_reg,
  output logic              misalign_fault,
  output logic              timeout_fault
);

  // Handshake: dmem_req rises with address/data/we already valid and all four
  // stay constant until the single-cycle dmem_ack pulse; req drops at that edge.

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         lat_ctl;
  logic [4:0]         lat_reg;
  logic [DATA_W-1:0]  lat_alu;
  logic               lat_load;

  logic memop;
  logic misaligned;
  logic timeout_hit;

  assign memop       = ex_valid & (memread | memwrite);
  assign misaligned  = |alu_result[1:0];
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    stall = 1'b0;
    if (state == IDLE) stall = memop & ~misaligned;
    else               stall = ~dmem_ack & ~timeout_hit;
  end

  assign pcsrc         = ex_valid & branch & zero;
  assign branch_target = add_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      lat_ctl        <= '0;
      lat_reg        <= '0;
      lat_alu        <= '0;
      lat_load       <= 1'b0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      wb_valid       <= 1'b0;
      wb_ctl         <= '0;
      read_data      <= '0;
      mem_alu_result <= '0;
      mem_wb_reg     <= '0;
      misalign_fault <= 1'b0;
      timeout_fault  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!ex_valid) begin
            wb_valid <= 1'b0;
            wb_ctl   <= '0;
          end else if (!memop) begin
            wb_valid       <= 1'b1;
            wb_ctl         <= wb_ctlout;
            mem_alu_result <= alu_result;
            mem_wb_reg     <= five_bit_muxout;
            read_data      <= '0;
          end else if (misaligned) begin
            misalign_fault <= 1'b1;
            wb_valid       <= 1'b0;
            wb_ctl         <= '0;
          end else begin
            // A store wins when both memread and memwrite are set.
            dmem_req   <= 1'b1;
            dmem_we    <= memwrite;
            dmem_addr  <= alu_result;
            dmem_wdata <= rdata2out;
            lat_ctl    <= wb_ctlout;
            lat_reg    <= five_bit_muxout;
            lat_alu    <= alu_result;
            lat_load   <= ~memwrite;
            cnt        <= '0;
            wb_valid   <= 1'b0;
            wb_ctl     <= '0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            dmem_req       <= 1'b0;
            wb_valid       <= 1'b1;
            wb_ctl         <= lat_ctl;
            read_data      <= lat_load ? dmem_rdata : '0;
            mem_alu_result <= lat_alu;
            mem_wb_reg     <= lat_reg;
            state          <= IDLE;
          end else if (timeout_hit) begin
            dmem_req      <= 1'b0;
            timeout_fault <= 1'b1;
            wb_valid      <= 1'b0;
            wb_ctl        <= '0;
            state         <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a vector table for single-cycle behaviour plus
// hand-written sequences for load, store, ack-in-IDLE, reset-in-ACCESS and timeout.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [1:0]  wb_ctlout;
  logic        branch, memread, memwrite, zero;
  logic [31:0] add_result, alu_result, rdata2out;
  logic [4:0]  five_bit_muxout;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall, pcsrc;
  logic [31:0] branch_target;
  logic        wb_valid;
  logic [1:0]  wb_ctl;
  logic [31:0] read_data, mem_alu_result;
  logic [4:0]  mem_wb_reg;
  logic        misalign_fault, timeout_fault;

  int checks   = 0;
  int failures = 0;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .wb_ctlout(wb_ctlout),
    .branch(branch), .memread(memread), .memwrite(memwrite),
    .add_result(add_result), .zero(zero), .alu_result(alu_result),
    .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .pcsrc(pcsrc), .branch_target(branch_target),
    .wb_valid(wb_valid), .wb_ctl(wb_ctl), .read_data(read_data),
    .mem_alu_result(mem_alu_result), .mem_wb_reg(mem_wb_reg),
    .misalign_fault(misalign_fault), .timeout_fault(timeout_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ev, br, zr, mr, mw;
    logic [1:0]  ctl;
    logic [31:0] alu, add;
    logic [4:0]  rd;
    logic        e_pcsrc, e_stall, e_wbv;
    logic [1:0]  e_ctl;
    logic [31:0] e_alu;
    logic [4:0]  e_rd;
    logic        e_mis;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ex_valid = 0; wb_ctlout = 0; branch = 0; memread = 0; memwrite = 0; zero = 0;
    add_result = 0; alu_result = 0; rdata2out = 0; five_bit_muxout = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   32'(dmem_req), 0);
    chk({tag, "_we"},    32'(dmem_we), 0);
    chk({tag, "_addr"},  dmem_addr, 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_wbv"},   32'(wb_valid), 0);
    chk({tag, "_ctl"},   32'(wb_ctl), 0);
    chk({tag, "_rdata"}, read_data, 0);
    chk({tag, "_alu"},   mem_alu_result, 0);
    chk({tag, "_rd"},    32'(mem_wb_reg), 0);
    chk({tag, "_mis"},   32'(misalign_fault), 0);
    chk({tag, "_tmo"},   32'(timeout_fault), 0);
  endtask

  initial begin
    int stall_cnt;
    int req_cycles;
    int stall_drop;

    //          ev br zr mr mw ctl    alu            add     rd   pcs stl wbv ectl   ealu           erd  mis
    vecs[0] = '{0, 1, 1, 0, 0, 2'b00, 32'h0,         32'h40, 5'd0, 0, 0, 0, 2'b00, 32'h0,         5'd0, 0};
    vecs[1] = '{1, 0, 0, 0, 0, 2'b10, 32'h7,         32'h0,  5'd5, 0, 0, 1, 2'b10, 32'h7,         5'd5, 0};
    vecs[2] = '{1, 1, 1, 0, 0, 2'b00, 32'h0,         32'h40, 5'd0, 1, 0, 1, 2'b00, 32'h0,         5'd0, 0};
    vecs[3] = '{1, 1, 0, 0, 0, 2'b10, 32'h10,        32'h40, 5'd3, 0, 0, 1, 2'b10, 32'h10,        5'd3, 0};
    vecs[4] = '{0, 0, 0, 0, 0, 2'b11, 32'h99,        32'h0,  5'd9, 0, 0, 0, 2'b00, 32'h10,        5'd3, 0};
    vecs[5] = '{1, 0, 0, 1, 0, 2'b11, 32'h102,       32'h0,  5'd7, 0, 0, 0, 2'b00, 32'h10,        5'd3, 1};
    vecs[6] = '{1, 0, 0, 0, 0, 2'b01, 32'hFFFFFFF0,  32'h0,  5'd31, 0, 0, 1, 2'b01, 32'hFFFFFFF0, 5'd31, 1};

    clear_inputs();
    do_reset();
    @(negedge clk);
    chk_all_zero("reset");

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ex_valid = vecs[i].ev; branch = vecs[i].br; zero = vecs[i].zr;
      memread = vecs[i].mr; memwrite = vecs[i].mw; wb_ctlout = vecs[i].ctl;
      alu_result = vecs[i].alu; add_result = vecs[i].add; five_bit_muxout = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_pcsrc", i), 32'(pcsrc), 32'(vecs[i].e_pcsrc));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_btgt", i), branch_target, vecs[i].add);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wbv", i), 32'(wb_valid), 32'(vecs[i].e_wbv));
      chk($sformatf("v%0d_ctl", i), 32'(wb_ctl), 32'(vecs[i].e_ctl));
      chk($sformatf("v%0d_alu", i), mem_alu_result, vecs[i].e_alu);
      chk($sformatf("v%0d_rd", i), 32'(mem_wb_reg), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_rdata", i), read_data, 0);
      chk($sformatf("v%0d_mis", i), 32'(misalign_fault), 32'(vecs[i].e_mis));
      chk($sformatf("v%0d_req", i), 32'(dmem_req), 0);
    end

    clear_inputs();
    do_reset();
    @(negedge clk);
    chk("rst2_mis", 32'(misalign_fault), 0);

    // Load at 0x100, ack three cycles after req is seen.
    stall_cnt = 0;
    @(negedge clk);
    ex_valid = 1; memread = 1; alu_result = 32'h100; wb_ctlout = 2'b11; five_bit_muxout = 5'd4;
    #1 if (stall) stall_cnt++;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      chk($sformatf("ld_req%0d", c), 32'(dmem_req), 1);
      chk($sformatf("ld_addr%0d", c), dmem_addr, 32'h100);
      chk($sformatf("ld_we%0d", c), 32'(dmem_we), 0);
      chk($sformatf("ld_wbv%0d", c), 32'(wb_valid), 0);
      if (stall) stall_cnt++;
    end
    @(negedge clk);
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    #1 chk("ld_ack_stall", 32'(stall), 0);
    @(posedge clk);
    #1 dmem_ack = 0; ex_valid = 0; memread = 0;
    chk("ld_stall_cnt", stall_cnt, 4);
    chk("ld_wbv", 32'(wb_valid), 1);
    chk("ld_rdata", read_data, 32'hDEADBEEF);
    chk("ld_ctl", 32'(wb_ctl), 2'b11);
    chk("ld_alu", mem_alu_result, 32'h100);
    chk("ld_rd", 32'(mem_wb_reg), 4);
    chk("ld_req_drop", 32'(dmem_req), 0);
    @(negedge clk); #1;
    chk("ld_no_reissue", 32'(dmem_req), 0);

    // Ack while IDLE must be ignored.
    @(negedge clk);
    dmem_ack = 1; dmem_rdata = 32'h55;
    @(posedge clk);
    #1 dmem_ack = 0;
    chk("idle_ack_wbv", 32'(wb_valid), 0);
    chk("idle_ack_rdata", read_data, 32'hDEADBEEF);
    chk("idle_ack_req", 32'(dmem_req), 0);

    // Store with memread also set: store wins, ack on first ACCESS cycle.
    stall_cnt = 0;
    @(negedge clk);
    ex_valid = 1; memwrite = 1; memread = 1; alu_result = 32'h20; rdata2out = 32'h1234;
    wb_ctlout = 2'b00; five_bit_muxout = 5'd0;
    #1 if (stall) stall_cnt++;
    @(negedge clk);
    chk("st_req", 32'(dmem_req), 1);
    chk("st_we", 32'(dmem_we), 1);
    chk("st_addr", dmem_addr, 32'h20);
    chk("st_wdata", dmem_wdata, 32'h1234);
    dmem_ack = 1; dmem_rdata = 32'hABCD;
    #1 if (stall) stall_cnt++;
    @(posedge clk);
    #1 dmem_ack = 0; ex_valid = 0; memwrite = 0; memread = 0;
    chk("st_stall_cnt", stall_cnt, 1);
    chk("st_wbv", 32'(wb_valid), 1);
    chk("st_rdata", read_data, 0);
    chk("st_req_drop", 32'(dmem_req), 0);

    // Reset during ACCESS: req drops, late ack is ignored.
    @(negedge clk);
    ex_valid = 1; memread = 1; alu_result = 32'h300; wb_ctlout = 2'b11; five_bit_muxout = 5'd6;
    @(negedge clk);
    chk("ra_req", 32'(dmem_req), 1);
    rst = 1; ex_valid = 0; memread = 0;
    @(posedge clk);
    #1 rst = 0;
    chk("ra_req_drop", 32'(dmem_req), 0);
    dmem_ack = 1; dmem_rdata = 32'h77;
    @(posedge clk);
    #1 dmem_ack = 0;
    chk("ra_wbv", 32'(wb_valid), 0);
    chk("ra_rdata", read_data, 0);
    chk("ra_req2", 32'(dmem_req), 0);

    // Timeout: no ack for 16 ACCESS cycles.
    req_cycles = 0;
    stall_drop = -1;
    @(negedge clk);
    ex_valid = 1; memread = 1; alu_result = 32'h200; wb_ctlout = 2'b11; five_bit_muxout = 5'd8;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (!dmem_req) break;
      req_cycles++;
      if (!stall && stall_drop < 0) begin
        stall_drop = req_cycles;
        @(posedge clk);
        #1 ex_valid = 0; memread = 0;
      end
    end
    chk("to_req_cycles", req_cycles, 16);
    chk("to_stall_drop", stall_drop, 16);
    chk("to_fault", 32'(timeout_fault), 1);
    chk("to_wbv", 32'(wb_valid), 0);
    chk("to_req", 32'(dmem_req), 0);

    clear_inputs();
    do_reset();
    @(negedge clk);
    chk_all_zero("rst3");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
